// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide execution unit.
//
// Takes register-file operands plus decoded funct3/rd, runs one operation at a
// time and returns a one-cycle writeback (rd_out, result, reg_write). Signed
// operands are converted to magnitudes at accept; the result sign is applied
// on the last iteration. Multiply is shift-add, divide is restoring, one bit
// per cycle. Divide by zero and signed overflow resolve in the first DIV cycle.
//
// Ports:
//   clock, reset_n    rising-edge clock, asynchronous active-low reset
//   start, flush      request (IDLE only) / synchronous abort
//   funct3            0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   rs1_data/rs2_data operands A and B, sampled at the accept edge only
//   rd_in             destination register index
//   busy              high while not IDLE
//   result, rd_out    registered writeback value and index
//   reg_write         one-cycle writeback strobe (never for x0, masked by flush)
//
// Build option: define MULDIV_FAST_MUL_EN to complete MUL* ops in one cycle
// with a single 33x33 signed multiply; divide is unchanged.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            reg_write
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic [4:0]       rd_q;
  logic             na_q, nb_q;  // operand A/B negative (only for signed operands)
  // MUL: hi_q:lo_q is the product accumulator, lo_q starts as |B|, b_q = |A|.
  // DIV: hi_q is the partial remainder, lo_q the dividend/quotient, b_q = |B|.
  logic [XLEN-1:0]  hi_q, lo_q, b_q;

  // Accept-side operand conditioning
  logic            sgn_a_d, sgn_b_d, na_d, nb_d;
  logic [XLEN-1:0] a_mag_d, b_mag_d;

  always_comb begin
    sgn_a_d = (funct3 != 3'd3) && (funct3 != 3'd5) && (funct3 != 3'd7);
    sgn_b_d = sgn_a_d && (funct3 != 3'd2);
    na_d    = sgn_a_d && rs1_data[XLEN-1];
    nb_d    = sgn_b_d && rs2_data[XLEN-1];
    a_mag_d = na_d ? -rs1_data : rs1_data;
    b_mag_d = nb_d ? -rs2_data : rs2_data;
  end

`ifdef MULDIV_FAST_MUL_EN
  // Single-cycle multiply on the re-signed operands; low 64 bits suffice.
  logic signed [XLEN:0] fa_d, fb_d;
  logic [2*XLEN-1:0]    fprod_d;
  logic [XLEN-1:0]      mul_res_d;

  always_comb begin
    fa_d      = na_q ? -$signed({1'b0, b_q}) : $signed({1'b0, b_q});
    fb_d      = nb_q ? -$signed({1'b0, lo_q}) : $signed({1'b0, lo_q});
    fprod_d   = {{(XLEN-1){fa_d[XLEN]}}, fa_d} * {{(XLEN-1){fb_d[XLEN]}}, fb_d};
    mul_res_d = (op_q == 3'd0) ? fprod_d[XLEN-1:0] : fprod_d[2*XLEN-1:XLEN];
  end
`else
  // One shift-add step: add multiplicand when multiplier LSB set, shift right.
  logic [XLEN:0]     msum_d;
  logic [XLEN-1:0]   mhi_d, mlo_d, mul_res_d;
  logic [2*XLEN-1:0] prod_d, prod_s_d;

  always_comb begin
    msum_d    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    mhi_d     = msum_d[XLEN:1];
    mlo_d     = {msum_d[0], lo_q[XLEN-1:1]};
    prod_d    = {mhi_d, mlo_d};
    prod_s_d  = (na_q ^ nb_q) ? -prod_d : prod_d;
    mul_res_d = (op_q == 3'd0) ? prod_s_d[XLEN-1:0] : prod_s_d[2*XLEN-1:XLEN];
  end
`endif

  // One restoring-divide step. The partial remainder stays below 2*|B|, so
  // bit XLEN of the trial difference is a clean borrow flag.
  logic [XLEN:0]   rsh_d, rdif_d;
  logic            ge_d;
  logic [XLEN-1:0] dhi_d, dlo_d, quot_d, rem_d, div_res_d;
  logic            bzero_d, ovf_d;
  logic [XLEN-1:0] spec_res_d;

  always_comb begin
    rsh_d     = {hi_q, lo_q[XLEN-1]};
    rdif_d    = rsh_d - {1'b0, b_q};
    ge_d      = !rdif_d[XLEN];
    dhi_d     = ge_d ? rdif_d[XLEN-1:0] : rsh_d[XLEN-1:0];
    dlo_d     = {lo_q[XLEN-2:0], ge_d};
    quot_d    = (na_q ^ nb_q) ? -dlo_d : dlo_d;
    rem_d     = na_q ? -dhi_d : dhi_d;
    div_res_d = op_q[1] ? rem_d : quot_d;
    // Special cases are judged on the untouched first-cycle operands.
    bzero_d   = (b_q == '0);
    ovf_d     = !op_q[0] && na_q && nb_q && (b_q == XLEN'(1)) &&
                (lo_q == {1'b1, {(XLEN-1){1'b0}}});
    if (bzero_d) spec_res_d = op_q[1] ? (na_q ? -lo_q : lo_q) : '1;
    else         spec_res_d = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      na_q    <= 1'b0;
      nb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            op_q  <= funct3;
            rd_q  <= rd_in;
            na_q  <= na_d;
            nb_q  <= nb_d;
            hi_q  <= '0;
            cnt_q <= '0;
            if (funct3[2]) begin
              lo_q    <= a_mag_d;
              b_q     <= b_mag_d;
              state_q <= S_DIV;
            end else begin
              lo_q    <= b_mag_d;
              b_q     <= a_mag_d;
              state_q <= S_MUL;
            end
          end
        end
        S_MUL: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            result  <= mul_res_d;
            rd_out  <= rd_q;
            state_q <= S_DONE;
`else
            hi_q  <= mhi_d;
            lo_q  <= mlo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN-1)) begin
              result  <= mul_res_d;
              rd_out  <= rd_q;
              state_q <= S_DONE;
            end
`endif
          end
        end
        S_DIV: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else if ((cnt_q == '0) && (bzero_d || ovf_d)) begin
            result  <= spec_res_d;
            rd_out  <= rd_q;
            state_q <= S_DONE;
          end else begin
            hi_q  <= dhi_d;
            lo_q  <= dlo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN-1)) begin
              result  <= div_res_d;
              rd_out  <= rd_q;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  // x0 is not protected by the register file, so suppress the strobe here.
  assign reg_write = (state_q == S_DONE) && (rd_out != 5'd0) && !flush;

endmodule
